// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling: resynchronises Rx, finds mid-bit
// sample points from a divided tick, and reports data, ready and error flags.
module uart_rx #(
  parameter int CLK_DIV = 326
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Rx,
  input  logic       RxRd,
  output logic [7:0] RxData,
  output logic       RxRdy,
  output logic       FrameErr,
  output logic       Overrun,
  output logic       RxBusy
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_sync;
  logic             r_rs;
  logic             r_rs_d;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_nxt;
  logic [3:0]       r_scnt;
  logic [3:0]       w_scnt_nxt;
  logic [2:0]       r_bit_idx;
  logic [2:0]       w_bit_nxt;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_nxt;
  logic [7:0]       r_data;
  logic [7:0]       w_data_nxt;
  logic             r_rdy;
  logic             w_rdy_nxt;
  logic             r_ferr;
  logic             w_ferr_nxt;
  logic             r_ovr;
  logic             w_ovr_nxt;
  logic             r_busy;
  logic             w_tick;
  logic             w_start;

  assign w_tick  = (r_div == DIV_LAST);
  assign w_start = r_rs_d & ~r_rs;

  // Two-flop synchroniser plus edge-detect history; idles high out of reset.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_sync <= 1'b1;
      r_rs   <= 1'b1;
      r_rs_d <= 1'b1;
    end else begin
      r_sync <= Rx;
      r_rs   <= r_sync;
      r_rs_d <= r_rs;
    end
  end

  // Next-state, counter and flag logic; frame completion overrides RxRd clearing.
  always_comb begin
    w_state_nxt = r_state;
    w_scnt_nxt  = r_scnt;
    w_bit_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_rdy_nxt   = RxRd ? 1'b0 : r_rdy;
    w_ferr_nxt  = RxRd ? 1'b0 : r_ferr;
    w_ovr_nxt   = RxRd ? 1'b0 : r_ovr;

    if (r_state == IDLE) begin
      w_div_nxt = '0;
    end else if (w_tick) begin
      w_div_nxt = '0;
    end else begin
      w_div_nxt = r_div + DIV_ONE;
    end

    if (w_tick) begin
      w_scnt_nxt = r_scnt + 4'd1;
    end else begin
      w_scnt_nxt = r_scnt;
    end

    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_nxt = START;
          w_scnt_nxt  = 4'd0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      START: begin
        if (w_tick && (r_scnt == 4'd7)) begin
          if (!r_rs) begin
            w_state_nxt = DATA;
            w_scnt_nxt  = 4'd0;
            w_bit_nxt   = 3'd0;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_state_nxt = START;
        end
      end
      DATA: begin
        if (w_tick && (r_scnt == 4'd15)) begin
          w_shift_nxt = {r_rs, r_shift[7:1]};
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = STOP;
          end else begin
            w_bit_nxt = r_bit_idx + 3'd1;
          end
        end else begin
          w_state_nxt = DATA;
        end
      end
      STOP: begin
        if (w_tick && (r_scnt == 4'd15)) begin
          w_state_nxt = IDLE;
          if (r_rs) begin
            w_data_nxt = r_shift;
            w_rdy_nxt  = 1'b1;
            w_ferr_nxt = 1'b0;
            if (r_rdy && !RxRd) begin
              w_ovr_nxt = 1'b1;
            end else begin
              w_ovr_nxt = RxRd ? 1'b0 : r_ovr;
            end
          end else begin
            w_ferr_nxt = 1'b1;
          end
        end else begin
          w_state_nxt = STOP;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state   <= IDLE;
      r_div     <= '0;
      r_scnt    <= 4'd0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
      r_data    <= 8'd0;
      r_rdy     <= 1'b0;
      r_ferr    <= 1'b0;
      r_ovr     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_div     <= w_div_nxt;
      r_scnt    <= w_scnt_nxt;
      r_bit_idx <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_data    <= w_data_nxt;
      r_rdy     <= w_rdy_nxt;
      r_ferr    <= w_ferr_nxt;
      r_ovr     <= w_ovr_nxt;
      r_busy    <= (w_state_nxt != IDLE);
    end
  end

  assign RxData   = r_data;
  assign RxRdy    = r_rdy;
  assign FrameErr = r_ferr;
  assign Overrun  = r_ovr;
  assign RxBusy   = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLK_DIV=4 (64 Clk per bit): edge-exact
// completion timing, glitch, framing, overrun, read/complete race and reset.
module tb_uart_rx;

  logic       Clk;
  logic       Rst;
  logic       Rx;
  logic       RxRd;
  logic [7:0] RxData;
  logic       RxRdy;
  logic       FrameErr;
  logic       Overrun;
  logic       RxBusy;

  int checks   = 0;
  int failures = 0;

  logic       pre_rdy, pre_busy;
  logic       snap_rdy, snap_ferr, snap_ovr, snap_busy;
  logic [7:0] snap_data;
  logic       busy_a, busy_b, busy_c, busy_seen;

  uart_rx #(.CLK_DIV(4)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Rx       (Rx),
    .RxRd     (RxRd),
    .RxData   (RxData),
    .RxRdy    (RxRdy),
    .FrameErr (FrameErr),
    .Overrun  (Overrun),
    .RxBusy   (RxBusy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Start bit begins after edge E0; edge n below is E(n). Snapshots at E610/E611.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int rd_at);
    logic [9:0] fb;
    fb = {stop_bit, data, 1'b0};
    @(posedge Clk); #1;
    Rx = fb[0];
    for (int n = 1; n <= 640; n++) begin
      @(posedge Clk); #1;
      if (n == 610) begin
        pre_rdy  = RxRdy;
        pre_busy = RxBusy;
      end
      if (n == 611) begin
        snap_rdy  = RxRdy;
        snap_data = RxData;
        snap_ferr = FrameErr;
        snap_ovr  = Overrun;
        snap_busy = RxBusy;
      end
      RxRd = (n == rd_at - 1) ? 1'b1 : 1'b0;
      if (n < 640) Rx = fb[n/64];
    end
  endtask

  task automatic pulse_rd();
    @(posedge Clk); #1;
    RxRd = 1'b1;
    @(posedge Clk); #1;
    RxRd = 1'b0;
  endtask

  initial begin
    Rst  = 1'b0;
    Rx   = 1'b1;
    RxRd = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check8("rst_data", RxData, 8'h00);
    check1("rst_rdy", RxRdy, 1'b0);
    check1("rst_ferr", FrameErr, 1'b0);
    check1("rst_ovr", Overrun, 1'b0);
    check1("rst_busy", RxBusy, 1'b0);
    Rst = 1'b1;
    repeat (5) @(posedge Clk);

    // basic byte with exact completion edge
    send_frame(8'hA5, 1'b1, 0);
    check1("basic_rdy_e610", pre_rdy, 1'b0);
    check1("basic_busy_e610", pre_busy, 1'b1);
    check1("basic_rdy_e611", snap_rdy, 1'b1);
    check8("basic_data", snap_data, 8'hA5);
    check1("basic_ferr", snap_ferr, 1'b0);
    check1("basic_ovr", snap_ovr, 1'b0);
    check1("basic_busy_e611", snap_busy, 1'b0);
    pulse_rd();
    check1("basic_rd_clear", RxRdy, 1'b0);
    check8("basic_data_kept", RxData, 8'hA5);

    // glitch: 12 Clk low, start check at E35 sees high
    @(posedge Clk); #1;
    Rx = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge Clk); #1;
      if (n == 12) Rx = 1'b1;
      if (n == 20) busy_a = RxBusy;
      if (n == 34) busy_b = RxBusy;
      if (n == 35) busy_c = RxBusy;
    end
    check1("glitch_busy_e20", busy_a, 1'b1);
    check1("glitch_busy_e34", busy_b, 1'b1);
    check1("glitch_busy_e35", busy_c, 1'b0);
    check1("glitch_rdy", RxRdy, 1'b0);
    check1("glitch_ferr", FrameErr, 1'b0);
    check8("glitch_data", RxData, 8'hA5);

    // framing error, then line held low
    send_frame(8'h3C, 1'b0, 0);
    check1("ferr_set", snap_ferr, 1'b1);
    check1("ferr_rdy", snap_rdy, 1'b0);
    check8("ferr_data_kept", snap_data, 8'hA5);
    busy_seen = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(posedge Clk); #1;
      if (RxBusy) busy_seen = 1'b1;
    end
    Rx = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(posedge Clk); #1;
      if (RxBusy) busy_seen = 1'b1;
    end
    check1("held_low_no_frame", busy_seen, 1'b0);
    check1("held_low_ferr_sticky", FrameErr, 1'b1);
    send_frame(8'h11, 1'b1, 0);
    check1("recover_ferr", snap_ferr, 1'b0);
    check8("recover_data", snap_data, 8'h11);
    check1("recover_rdy", snap_rdy, 1'b1);
    pulse_rd();
    check1("recover_rd_clear", RxRdy, 1'b0);

    // overrun
    send_frame(8'h01, 1'b1, 0);
    check8("ovr_first_data", snap_data, 8'h01);
    check1("ovr_first_ovr", snap_ovr, 1'b0);
    send_frame(8'h02, 1'b1, 0);
    check8("ovr_data", snap_data, 8'h02);
    check1("ovr_rdy", snap_rdy, 1'b1);
    check1("ovr_set", snap_ovr, 1'b1);
    pulse_rd();
    check1("ovr_rd_rdy", RxRdy, 1'b0);
    check1("ovr_rd_ovr", Overrun, 1'b0);

    // read strobe exactly at stop-sample edge
    send_frame(8'h5A, 1'b1, 0);
    check1("race_first_rdy", snap_rdy, 1'b1);
    send_frame(8'hC3, 1'b1, 611);
    check1("race_rdy", snap_rdy, 1'b1);
    check1("race_ovr", snap_ovr, 1'b0);
    check8("race_data", snap_data, 8'hC3);
    check1("race_ferr", snap_ferr, 1'b0);

    // asynchronous reset during data bit 3
    @(posedge Clk); #1;
    Rx = 1'b0;
    repeat (280) @(posedge Clk);
    #1;
    check1("midrst_busy_before", RxBusy, 1'b1);
    check1("midrst_rdy_before", RxRdy, 1'b1);
    Rst = 1'b0;
    #2;
    check8("midrst_data", RxData, 8'h00);
    check1("midrst_rdy", RxRdy, 1'b0);
    check1("midrst_ferr", FrameErr, 1'b0);
    check1("midrst_ovr", Overrun, 1'b0);
    check1("midrst_busy", RxBusy, 1'b0);
    Rx = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    Rst = 1'b1;
    repeat (5) @(posedge Clk);
    send_frame(8'hFF, 1'b1, 0);
    check8("after_rst_data", snap_data, 8'hFF);
    check1("after_rst_rdy", snap_rdy, 1'b1);
    check1("after_rst_ferr", snap_ferr, 1'b0);
    check1("after_rst_ovr", snap_ovr, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
